// File: rtl/tour_cmd.sv
// Replays a solved knight's tour as vertical/horizontal move commands.
// Optional macro TOUR_CMD_FANFARE_EN: horizontal leg uses fanfare opcode.
`timescale 1ns/1ps
module tour_cmd #(
  parameter logic [4:0] LAST_INDX = 5'd23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } state_t;

  localparam logic [3:0] MOVE_OP = 4'b0010;
`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] HORZ_OP = 4'b0011;
`else
  localparam logic [3:0] HORZ_OP = 4'b0010;
`endif

  state_t      state;
  state_t      nxt;
  logic        dx_neg;
  logic        dy_neg;
  logic [1:0]  dx_mag;
  logic [1:0]  dy_mag;
  logic        last;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;

  // Decode one-hot move; anything else falls back to (+2,+1)
  always_comb begin
    dx_neg = 1'b0;
    dy_neg = 1'b0;
    dx_mag = 2'd2;
    dy_mag = 2'd1;
    case (move)
      8'h01: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_mag = 2'd2; end
      8'h02: begin dx_mag = 2'd1; dy_mag = 2'd2; end
      8'h04: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_mag = 2'd1; end
      8'h08: begin
        dx_neg = 1'b1; dy_neg = 1'b1;
        dx_mag = 2'd2; dy_mag = 2'd1;
      end
      8'h10: begin
        dx_neg = 1'b1; dy_neg = 1'b1;
        dx_mag = 2'd1; dy_mag = 2'd2;
      end
      8'h20: begin dy_neg = 1'b1; dx_mag = 2'd1; dy_mag = 2'd2; end
      8'h40: begin dy_neg = 1'b1; dx_mag = 2'd2; dy_mag = 2'd1; end
      default: begin dx_mag = 2'd2; dy_mag = 2'd1; end
    endcase
  end

  assign last = (mv_indx == LAST_INDX);

  assign vert_cmd = {MOVE_OP, dy_neg ? 8'h7F : 8'h00,
                     2'b00, dy_mag};
  assign horz_cmd = {HORZ_OP, dx_neg ? 8'h3F : 8'hBF,
                     2'b00, dx_mag};

  // State register with synchronous abort
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Replay index: cleared on tour start, advanced after each move
  always_ff @(posedge clk) begin
    if (rst)
      mv_indx <= 5'd0;
    else if (state == IDLE && start_tour)
      mv_indx <= 5'd0;
    else if (state == WAIT_H && send_resp && !last)
      mv_indx <= mv_indx + 5'd1;
  end

  // Next state and command/handshake muxing
  always_comb begin
    nxt              = state;
    cmd              = vert_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = 8'hA5;
    unique case (state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = 8'h5A;
        if (start_tour) nxt = VERT;
      end
      VERT: begin
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) nxt = WAIT_V;
      end
      WAIT_V: begin
        if (send_resp) nxt = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) nxt = WAIT_H;
      end
      WAIT_H: begin
        cmd = horz_cmd;
        if (last) resp = 8'h5A;
        if (send_resp) nxt = last ? IDLE : VERT;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule
